// File: rtl/barrido_entradas_pkg.sv
// rtl/barrido_entradas_pkg.sv - shared constants for the input-sweep sequencer
// Purpose: FSM state encoding, signature width/polynomial and the
//          one-step signature update used by the signature register.
package barrido_entradas_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int              SIG_W    = 16;
    localparam logic [SIG_W-1:0] SIG_POLY = 16'h1021;

    // Shift left, fold the polynomial back in when the MSB falls out,
    // then mix in the (already zero-extended) response word.
    function automatic logic [SIG_W-1:0] sig_step(input logic [SIG_W-1:0] sig,
                                                  input logic [SIG_W-1:0] data);
        return {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? SIG_POLY : '0) ^ data;
    endfunction

endpackage

// File: rtl/firma_crc16.sv
// rtl/firma_crc16.sv - 16-bit response signature register
// Purpose: accumulates sampled responses into a running signature.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   clr_i        clear signature to 0 (wins over en_i)
//   en_i         fold data_i into the signature this edge
//   data_i [M]   response word, zero-extended to 16 bits
//   sig_o [16]   current signature
module firma_crc16
    import barrido_entradas_pkg::*;
#(
    parameter int M = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [M-1:0]     data_i,
    output logic [SIG_W-1:0] sig_o
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr_i) begin
            sig_d = '0;
        end else if (en_i) begin
            sig_d = sig_step(sig_q, SIG_W'(data_i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/barrido_entradas.sv
// rtl/barrido_entradas.sv - exhaustive input sweep sequencer with signature
// Purpose: drives every K-bit vector 0..2^K-1 into a combinational unit,
//          waits SETTLE un-held cycles, samples y_in, strobes it out and
//          folds it into a 16-bit signature.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, abort, hold  control: begin sweep / return to idle / freeze settle
//   y_in [M]            response of the unit under test
//   x_out [K]           vector currently driven
//   sample_valid        one-cycle strobe qualifying sample_idx / sample_y
//   sample_idx [K]      vector index of the strobed sample
//   sample_y [M]        captured response
//   busy, done          sweep in progress / sweep complete
//   signature [16]      running response signature
module barrido_entradas
    import barrido_entradas_pkg::*;
#(
    parameter int K      = 1,
    parameter int M      = 1,
    parameter int SETTLE = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic         hold,
    input  logic [M-1:0] y_in,
    output logic [K-1:0] x_out,
    output logic         sample_valid,
    output logic [K-1:0] sample_idx,
    output logic [M-1:0] sample_y,
    output logic         busy,
    output logic         done,
    output logic [15:0]  signature
);

    localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
    localparam logic [K-1:0]    X_LAST   = '1;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [K-1:0]  x_q,     x_d;
    logic [K-1:0]  idx_q,   idx_d;
    logic [M-1:0]  y_q,     y_d;
    logic          sv_q,    sv_d;
    logic          sig_clr;
    logic          sig_en;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        idx_d   = idx_q;
        y_d     = y_q;
        sv_d    = 1'b0;
        sig_clr = 1'b0;
        sig_en  = 1'b0;
        // abort wins over everything except reset; an in-flight SAMPLE is
        // dropped, so no strobe and no signature update for that vector.
        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            x_d     = '0;
            sig_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d   = '0;
                    x_d     = '0;
                    sig_clr = 1'b1;
                    if (start) begin
                        state_d = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (!hold) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            state_d = ST_SAMPLE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_SAMPLE: begin
                    idx_d  = x_q;
                    y_d    = y_in;
                    sv_d   = 1'b1;
                    sig_en = 1'b1;
                    if (x_q == X_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        x_d     = x_q + 1'b1;
                        state_d = ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        x_d     = '0;
                        cnt_d   = '0;
                        sig_clr = 1'b1;
                        state_d = ST_SETTLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            idx_q   <= '0;
            y_q     <= '0;
            sv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            idx_q   <= idx_d;
            y_q     <= y_d;
            sv_q    <= sv_d;
        end
    end

    firma_crc16 #(.M(M)) u_firma (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (sig_clr),
        .en_i   (sig_en),
        .data_i (y_in),
        .sig_o  (signature)
    );

    assign x_out        = x_q;
    assign sample_valid = sv_q;
    assign sample_idx   = idx_q;
    assign sample_y     = y_q;
    assign busy         = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_barrido_entradas.sv
// tb/tb_barrido_entradas.sv - scoreboard bench for barrido_entradas
module tb_barrido_entradas;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus variables, shared by both instances through a selector.
    logic por     = 1'b1;
    logic start_r = 1'b0;
    logic abort_r = 1'b0;
    logic hold_r  = 1'b0;
    logic reset_r = 1'b0;
    bit   go_sel  = 1'b0;
    logic [3:0] tbl_a = 4'b0110;

    // Instance A: K=2, M=1, SETTLE=2
    logic       rst_a, st_a, ab_a, hd_a, y_a, sv_a, busy_a, done_a, sy_a;
    logic [1:0] x_a, idx_a;
    logic [15:0] sig_a;
    // Instance B: K=1, M=1, SETTLE=1
    logic       rst_b, st_b, ab_b, hd_b, y_b, sv_b, busy_b, done_b, sy_b;
    logic [0:0] x_b, idx_b;
    logic [15:0] sig_b;

    assign rst_a = por | (reset_r & ~go_sel);
    assign st_a  = start_r & ~go_sel;
    assign ab_a  = abort_r & ~go_sel;
    assign hd_a  = hold_r  & ~go_sel;
    assign y_a   = tbl_a[x_a];
    assign rst_b = por | (reset_r & go_sel);
    assign st_b  = start_r & go_sel;
    assign ab_b  = abort_r & go_sel;
    assign hd_b  = hold_r  & go_sel;
    assign y_b   = ~x_b[0];

    barrido_entradas #(.K(2), .M(1), .SETTLE(2)) dut_a (
        .clk(clk), .reset(rst_a), .start(st_a), .abort(ab_a), .hold(hd_a),
        .y_in(y_a), .x_out(x_a), .sample_valid(sv_a), .sample_idx(idx_a),
        .sample_y(sy_a), .busy(busy_a), .done(done_a), .signature(sig_a)
    );

    barrido_entradas #(.K(1), .M(1), .SETTLE(1)) dut_b (
        .clk(clk), .reset(rst_b), .start(st_b), .abort(ab_b), .hold(hd_b),
        .y_in(y_b), .x_out(x_b), .sample_valid(sv_b), .sample_idx(idx_b),
        .sample_y(sy_b), .busy(busy_b), .done(done_b), .signature(sig_b)
    );

    int busy_m, done_m, x_m, sig_m, sv_m, idx_m, y_m;
    always_comb begin
        if (go_sel) begin
            busy_m = int'(busy_b); done_m = int'(done_b); x_m = int'(x_b);
            sig_m = int'(sig_b); sv_m = int'(sv_b); idx_m = int'(idx_b); y_m = int'(sy_b);
        end else begin
            busy_m = int'(busy_a); done_m = int'(done_a); x_m = int'(x_a);
            sig_m = int'(sig_a); sv_m = int'(sv_a); idx_m = int'(idx_a); y_m = int'(sy_a);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int idx;
        int y;
        int sig;
    } exp_t;
    exp_t exp_q[$];

    // Monitor: every strobe from either instance must match the next entry.
    always @(negedge clk) begin
        exp_t e;
        if (sv_a || sv_b) begin
            if (sv_a && sv_b) check("both_strobe", 1, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", sv_a ? int'(idx_a) : int'(idx_b), -1);
            end else begin
                e = exp_q.pop_front();
                check("sample_idx", sv_a ? int'(idx_a) : int'(idx_b), e.idx);
                check("sample_y",   sv_a ? int'(sy_a)  : int'(sy_b),  e.y);
                check("sample_sig", sv_a ? int'(sig_a) : int'(sig_b), e.sig);
            end
        end
    end

    // Reference model phases: where the sweep is, in plain terms.
    localparam int PH_IDLE = 0, PH_SET = 1, PH_SAM = 2, PH_DONE = 3;
    bit hold_pat [0:63];

    function automatic int resp(input int sel, input int v);
        if (sel != 0) return (v & 1) ^ 1;
        return int'(tbl_a[v]);
    endfunction

    function automatic int sig_next(input int s, input int y);
        return ((s << 1) & 16'hFFFF) ^ (((s & 16'h8000) != 0) ? 16'h1021 : 0) ^ y;
    endfunction

    // Accept start on edge E0, then step cycle by cycle for max_c cycles.
    // Cycle c is the interval after edge E(c-1); its inputs act on edge E(c).
    task automatic sweep(input int sel, input int max_c, input int abort_c,
                         input int reset_c, input int startb_c,
                         output int done_cyc, output int busy_cnt, output int held);
        int k, s, n, v, e, ph, msig, y;
        bit rst_seen;
        exp_t ent;
        k = (sel != 0) ? 1 : 2;
        s = (sel != 0) ? 1 : 2;
        n = (1 << k) - 1;
        done_cyc = -1; busy_cnt = 0; held = 0; rst_seen = 0;
        @(negedge clk);
        go_sel = (sel != 0); start_r = 1'b1; abort_r = 1'b0; reset_r = 1'b0; hold_r = 1'b0;
        v = 0; e = 0; ph = PH_SET; msig = 0;
        for (int c = 1; c <= max_c; c++) begin
            @(negedge clk);
            check("busy",      busy_m, (ph == PH_SET || ph == PH_SAM) ? 1 : 0);
            check("done",      done_m, (ph == PH_DONE) ? 1 : 0);
            check("x_out",     x_m, v);
            check("signature", sig_m, msig);
            if (rst_seen) begin
                check("rst_sample_valid", sv_m, 0);
                check("rst_sample_idx",   idx_m, 0);
                check("rst_sample_y",     y_m, 0);
                rst_seen = 0;
            end
            if (busy_m != 0) busy_cnt++;
            if (done_m != 0 && done_cyc < 0) done_cyc = c - 1;
            start_r = (c == startb_c);
            abort_r = (c == abort_c);
            reset_r = (c == reset_c);
            hold_r  = hold_pat[c];
            if (c == reset_c) begin
                ph = PH_IDLE; v = 0; e = 0; msig = 0; rst_seen = 1;
            end else if (c == abort_c) begin
                ph = PH_IDLE; v = 0; e = 0; msig = 0;
            end else if (c == startb_c && (ph == PH_IDLE || ph == PH_DONE)) begin
                ph = PH_SET; v = 0; e = 0; msig = 0;
            end else begin
                case (ph)
                    PH_SET: begin
                        if (hold_pat[c]) held++;
                        else e++;
                        if (e == s) begin
                            ph = PH_SAM; e = 0;
                        end
                    end
                    PH_SAM: begin
                        y = resp(sel, v);
                        msig = sig_next(msig, y);
                        ent.idx = v; ent.y = y; ent.sig = msig;
                        exp_q.push_back(ent);
                        if (v == n) ph = PH_DONE;
                        else begin
                            v++; ph = PH_SET;
                        end
                    end
                    default: ;
                endcase
            end
        end
        start_r = 1'b0; abort_r = 1'b0; reset_r = 1'b0; hold_r = 1'b0;
        @(negedge clk);
        check("missing_samples", exp_q.size(), 0);
        exp_q.delete();
    endtask

    int dc, bc, hc;

    initial begin
        repeat (3) @(negedge clk);
        por = 1'b0;
        check("rst_x_a", int'(x_a), 0);
        check("rst_busy_a", int'(busy_a), 0);
        check("rst_done_a", int'(done_a), 0);
        check("rst_sv_a", int'(sv_a), 0);
        check("rst_sig_a", int'(sig_a), 0);
        check("rst_idx_a", int'(idx_a), 0);
        check("rst_y_a", int'(sy_a), 0);
        check("rst_done_b", int'(done_b), 0);
        check("rst_sig_b", int'(sig_b), 0);

        // Basic sweep, y = x[0]^x[1]
        tbl_a = 4'b0110;
        hold_pat = '{default: 1'b0};
        sweep(0, 16, -1, -1, -1, dc, bc, hc);
        check("basic_done_lat", dc, 12);
        check("basic_busy_cnt", bc, 12);
        check("basic_sig", sig_m, 16'h0006);

        // Restart from DONE with a start pulsed while busy
        sweep(0, 16, -1, -1, 5, dc, bc, hc);
        check("restart_done_lat", dc, 12);
        check("restart_sig", sig_m, 16'h0006);

        // Hold for 3 cycles in vector 1's settle window
        hold_pat[4] = 1'b1; hold_pat[5] = 1'b1; hold_pat[6] = 1'b1;
        sweep(0, 20, -1, -1, -1, dc, bc, hc);
        check("hold_done_lat", dc, 15);
        check("hold_sig", sig_m, 16'h0006);
        hold_pat = '{default: 1'b0};

        // Abort during vector 2's settle, then a full sweep
        sweep(0, 14, 7, -1, -1, dc, bc, hc);
        check("abort_no_done", dc, -1);
        sweep(0, 16, -1, -1, -1, dc, bc, hc);
        check("post_abort_done_lat", dc, 12);
        check("post_abort_sig", sig_m, 16'h0006);

        // Reset during vector 1's sample cycle
        sweep(0, 12, -1, 6, -1, dc, bc, hc);
        check("reset_no_done", dc, -1);

        // Random response tables, hold patterns and busy-time starts
        for (int r = 0; r < 6; r++) begin
            tbl_a = 4'($urandom);
            hold_pat = '{default: 1'b0};
            for (int c = 1; c <= 20; c++) hold_pat[c] = ($urandom_range(3) == 0);
            sweep(0, 40, -1, -1, int'($urandom_range(1, 8)), dc, bc, hc);
            check("rand_done_lat", dc, 4 * (2 + 1) + hc);
        end
        hold_pat = '{default: 1'b0};

        // K=1, SETTLE=1, y = ~x
        sweep(1, 8, -1, -1, -1, dc, bc, hc);
        check("k1_done_lat", dc, 4);
        check("k1_sig", sig_m, 16'h0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
